// File: rtl/pipe_ctrl.sv
// Pipeline controller: turns hazard, branch, exception and CP2 status into
// per-stage stall/flush controls and a PC redirect, and sequences CP2 waits.
module pipe_ctrl #(
  parameter int                ADDR_W      = 30,
  parameter logic [ADDR_W-1:0] EXC_VECTOR  = 'h40,
  parameter int                CP2_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ext_stall,
  input  logic              ld_hazard,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              id_en,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [2:0]        id_exp_code,
  input  logic              cp_irenable_0,
  input  logic              cp2_busy,
  input  logic              cp2_done,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic              redirect_en,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] epc,
  output logic [2:0]        exc_code,
  output logic              cp2_timeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_CP2_WAIT = 2'd1,
    ST_EXC      = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(CP2_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_next;
  logic [ADDR_W-1:0] r_epc;
  logic [2:0]        r_exc_code;
  logic              r_cp2_timeout;

  logic              w_exc;
  logic              w_exc_take;
  logic              w_tmo_take;
  logic              w_if_stall;
  logic              w_id_stall;
  logic              w_ex_stall;
  logic              w_mem_stall;
  logic              w_if_flush;
  logic              w_id_flush;
  logic              w_ex_flush;
  logic              w_mem_flush;
  logic              w_redirect_en;
  logic [ADDR_W-1:0] w_redirect_pc;

  assign w_exc = id_en && (id_exp_code != 3'd0);

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_exc_take    = 1'b0;
    w_tmo_take    = 1'b0;
    w_if_stall    = 1'b0;
    w_id_stall    = 1'b0;
    w_ex_stall    = 1'b0;
    w_mem_stall   = 1'b0;
    w_if_flush    = 1'b0;
    w_id_flush    = 1'b0;
    w_ex_flush    = 1'b0;
    w_mem_flush   = 1'b0;
    w_redirect_en = 1'b0;
    w_redirect_pc = '0;

    case (r_state)
      ST_RUN: begin
        if (w_exc) begin
          w_if_flush   = 1'b1;
          w_id_flush   = 1'b1;
          w_ex_flush   = 1'b1;
          w_exc_take   = 1'b1;
          w_state_next = ST_EXC;
        end else if (ext_stall) begin
          w_if_stall  = 1'b1;
          w_id_stall  = 1'b1;
          w_ex_stall  = 1'b1;
          w_mem_stall = 1'b1;
        end else if (cp_irenable_0 && cp2_busy) begin
          w_if_stall   = 1'b1;
          w_id_stall   = 1'b1;
          w_ex_stall   = 1'b1;
          w_cnt_next   = 8'd0;
          w_state_next = ST_CP2_WAIT;
        end else if (ld_hazard) begin
          // Hold IF/ID and push one bubble into EX per hazard cycle.
          w_if_stall = 1'b1;
          w_id_stall = 1'b1;
          w_ex_flush = 1'b1;
        end else if (br_taken) begin
          w_redirect_en = 1'b1;
          w_redirect_pc = br_addr;
          w_if_flush    = 1'b1;
        end
      end

      ST_CP2_WAIT: begin
        if (cp2_done) begin
          // The done pulse is never lost; a concurrent ext_stall only freezes.
          if (ext_stall) begin
            w_if_stall  = 1'b1;
            w_id_stall  = 1'b1;
            w_ex_stall  = 1'b1;
            w_mem_stall = 1'b1;
          end
          w_state_next = ST_RUN;
        end else if (ext_stall) begin
          w_if_stall  = 1'b1;
          w_id_stall  = 1'b1;
          w_ex_stall  = 1'b1;
          w_mem_stall = 1'b1;
        end else if (r_cnt == TMO_LAST) begin
          w_if_flush   = 1'b1;
          w_id_flush   = 1'b1;
          w_ex_flush   = 1'b1;
          w_tmo_take   = 1'b1;
          w_state_next = ST_EXC;
        end else begin
          w_if_stall  = 1'b1;
          w_id_stall  = 1'b1;
          w_ex_stall  = 1'b1;
          w_mem_flush = 1'b1;
          w_cnt_next  = r_cnt + 8'd1;
        end
      end

      ST_EXC: begin
        w_redirect_en = 1'b1;
        w_redirect_pc = EXC_VECTOR;
        w_if_flush    = 1'b1;
        w_state_next  = ST_RUN;
      end

      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_cnt         <= 8'd0;
      r_epc         <= '0;
      r_exc_code    <= 3'd0;
      r_cp2_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_exc_take) begin
        r_epc      <= id_pc;
        r_exc_code <= id_exp_code;
      end
      if (w_tmo_take) begin
        r_epc         <= id_pc;
        r_exc_code    <= 3'd7;
        r_cp2_timeout <= 1'b1;
      end
    end
  end

  // Controls are forced low while reset is held so nothing leaks during reset.
  assign if_stall    = reset & w_if_stall;
  assign id_stall    = reset & w_id_stall;
  assign ex_stall    = reset & w_ex_stall;
  assign mem_stall   = reset & w_mem_stall;
  assign if_flush    = reset & w_if_flush;
  assign id_flush    = reset & w_id_flush;
  assign ex_flush    = reset & w_ex_flush;
  assign mem_flush   = reset & w_mem_flush;
  assign redirect_en = reset & w_redirect_en;
  assign redirect_pc = reset ? w_redirect_pc : '0;
  assign epc         = r_epc;
  assign exc_code    = r_exc_code;
  assign cp2_timeout = r_cp2_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus a short-timeout instance.
module tb_pipe_ctrl;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          ext_stall, ld_hazard, br_taken, id_en;
  logic          cp_irenable_0, cp2_busy, cp2_done;
  logic [AW-1:0] br_addr, id_pc;
  logic [2:0]    id_exp_code;

  logic          m_if_stall, m_id_stall, m_ex_stall, m_mem_stall;
  logic          m_if_flush, m_id_flush, m_ex_flush, m_mem_flush, m_redirect_en;
  logic [AW-1:0] m_redirect_pc, m_epc;
  logic [2:0]    m_exc_code;
  logic          m_cp2_timeout;

  logic          t_if_stall, t_id_stall, t_ex_stall, t_mem_stall;
  logic          t_if_flush, t_id_flush, t_ex_flush, t_mem_flush, t_redirect_en;
  logic [AW-1:0] t_redirect_pc, t_epc;
  logic [2:0]    t_exc_code;
  logic          t_cp2_timeout;

  logic [8:0]    ctrl_m, ctrl_t;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_stall;

  always #5 clk = ~clk;

  // {if_stall,id_stall,ex_stall,mem_stall,if_flush,id_flush,ex_flush,mem_flush,redirect_en}
  assign ctrl_m = {m_if_stall, m_id_stall, m_ex_stall, m_mem_stall,
                   m_if_flush, m_id_flush, m_ex_flush, m_mem_flush, m_redirect_en};
  assign ctrl_t = {t_if_stall, t_id_stall, t_ex_stall, t_mem_stall,
                   t_if_flush, t_id_flush, t_ex_flush, t_mem_flush, t_redirect_en};

  pipe_ctrl u_dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .ld_hazard(ld_hazard),
    .br_taken(br_taken), .br_addr(br_addr), .id_en(id_en), .id_pc(id_pc),
    .id_exp_code(id_exp_code), .cp_irenable_0(cp_irenable_0), .cp2_busy(cp2_busy),
    .cp2_done(cp2_done), .if_stall(m_if_stall), .id_stall(m_id_stall),
    .ex_stall(m_ex_stall), .mem_stall(m_mem_stall), .if_flush(m_if_flush),
    .id_flush(m_id_flush), .ex_flush(m_ex_flush), .mem_flush(m_mem_flush),
    .redirect_en(m_redirect_en), .redirect_pc(m_redirect_pc), .epc(m_epc),
    .exc_code(m_exc_code), .cp2_timeout(m_cp2_timeout)
  );

  pipe_ctrl #(.CP2_TIMEOUT(4)) u_dut_t4 (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .ld_hazard(ld_hazard),
    .br_taken(br_taken), .br_addr(br_addr), .id_en(id_en), .id_pc(id_pc),
    .id_exp_code(id_exp_code), .cp_irenable_0(cp_irenable_0), .cp2_busy(cp2_busy),
    .cp2_done(cp2_done), .if_stall(t_if_stall), .id_stall(t_id_stall),
    .ex_stall(t_ex_stall), .mem_stall(t_mem_stall), .if_flush(t_if_flush),
    .id_flush(t_id_flush), .ex_flush(t_ex_flush), .mem_flush(t_mem_flush),
    .redirect_en(t_redirect_en), .redirect_pc(t_redirect_pc), .epc(t_epc),
    .exc_code(t_exc_code), .cp2_timeout(t_cp2_timeout)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic quiet();
    ext_stall = 0; ld_hazard = 0; br_taken = 0; br_addr = '0; id_en = 0;
    id_pc = '0; id_exp_code = 3'd0; cp_irenable_0 = 0; cp2_busy = 0; cp2_done = 0;
  endtask

  initial begin
    quiet();
    reset = 1'b0;
    repeat (2) samp();
    chk_eq("rst_ctrl", 32'(ctrl_m), 32'h0);
    chk_eq("rst_epc", 32'(m_epc), 32'h0);
    chk_eq("rst_code", 32'(m_exc_code), 32'h0);
    chk_eq("rst_tmo", 32'(m_cp2_timeout), 32'h0);
    step(); reset = 1'b1;
    samp(); chk_eq("idle_ctrl", 32'(ctrl_m), 32'h0);
    $display("reset phase done");

    // load hazard for two cycles
    step(); ld_hazard = 1; samp(); chk_eq("ld_c1", 32'(ctrl_m), 32'(9'b110000100));
    step();                samp(); chk_eq("ld_c2", 32'(ctrl_m), 32'(9'b110000100));
    step(); ld_hazard = 0; samp(); chk_eq("ld_off", 32'(ctrl_m), 32'h0);
    $display("load hazard phase done");

    // branch, then branch blocked by hazard
    step(); br_taken = 1; br_addr = 30'h100; samp();
    chk_eq("br_ctrl", 32'(ctrl_m), 32'(9'b000010001));
    chk_eq("br_pc", 32'(m_redirect_pc), 32'h100);
    step(); ld_hazard = 1; samp();
    chk_eq("br_ld_ctrl", 32'(ctrl_m), 32'(9'b110000100));
    step(); quiet(); id_exp_code = 3'd3; br_taken = 1; br_addr = 30'h2A0; samp();
    chk_eq("br_noen_ctrl", 32'(ctrl_m), 32'(9'b000010001));
    chk_eq("br_noen_pc", 32'(m_redirect_pc), 32'h2A0);
    $display("branch phase done");

    // exception beats branch; vector redirect next cycle
    step(); quiet(); id_en = 1; id_exp_code = 3'd2; id_pc = 30'h55;
    br_taken = 1; br_addr = 30'h100; samp();
    chk_eq("exc_ctrl", 32'(ctrl_m), 32'(9'b000011100));
    step(); id_exp_code = 3'd5; id_pc = 30'h77; samp();
    chk_eq("exc_vec_ctrl", 32'(ctrl_m), 32'(9'b000010001));
    chk_eq("exc_vec_pc", 32'(m_redirect_pc), 32'h40);
    chk_eq("exc_epc", 32'(m_epc), 32'h55);
    chk_eq("exc_code", 32'(m_exc_code), 32'h2);
    step(); quiet(); samp();
    chk_eq("exc_after_ctrl", 32'(ctrl_m), 32'h0);
    chk_eq("exc_after_epc", 32'(m_epc), 32'h55);
    chk_eq("exc_after_code", 32'(m_exc_code), 32'h2);
    $display("exception phase done");

    // ext_stall outranks load hazard
    step(); ext_stall = 1; ld_hazard = 1; samp();
    chk_eq("ext_ctrl", 32'(ctrl_m), 32'(9'b111100000));
    step(); quiet(); samp();
    $display("ext_stall phase done");

    // CP2 issue, five wait cycles, release on done
    n_stall = 0;
    step(); cp_irenable_0 = 1; cp2_busy = 1; samp();
    chk_eq("cp2_issue", 32'(ctrl_m), 32'(9'b111000000));
    if (m_if_stall) n_stall++;
    for (int i = 0; i < 5; i++) begin
      step(); samp();
      chk_eq("cp2_wait", 32'(ctrl_m), 32'(9'b111000010));
      if (m_if_stall) n_stall++;
    end
    step(); cp2_done = 1; cp2_busy = 0; cp_irenable_0 = 0; samp();
    chk_eq("cp2_done", 32'(ctrl_m), 32'h0);
    if (m_if_stall) n_stall++;
    step(); cp2_done = 0; samp();
    chk_eq("cp2_post", 32'(ctrl_m), 32'h0);
    chk_eq("cp2_stall_cycles", 32'(n_stall), 32'd6);
    $display("cp2 completion phase done");

    // asynchronous reset in the middle of CP2_WAIT
    step(); cp_irenable_0 = 1; cp2_busy = 1; ld_hazard = 1; samp();
    step(); samp();
    chk_eq("pre_rst_wait", 32'(ctrl_m), 32'(9'b111000010));
    reset = 1'b0; #1;
    chk_eq("arst_ctrl", 32'(ctrl_m), 32'h0);
    chk_eq("arst_epc", 32'(m_epc), 32'h0);
    chk_eq("arst_tmo", 32'(m_cp2_timeout), 32'h0);
    chk_eq("arst_t4_tmo", 32'(t_cp2_timeout), 32'h0);
    quiet();
    step(); step(); reset = 1'b1; samp();
    chk_eq("arst_run", 32'(ctrl_m), 32'h0);
    $display("async reset phase done");

    // CP2 timeout on the 4-cycle instance with a 2-cycle ext_stall
    step(); cp_irenable_0 = 1; cp2_busy = 1; id_pc = 30'h123; samp();
    chk_eq("t4_issue", 32'(ctrl_t), 32'(9'b111000000));
    step(); samp(); chk_eq("t4_w0", 32'(ctrl_t), 32'(9'b111000010));
    step(); samp(); chk_eq("t4_w1", 32'(ctrl_t), 32'(9'b111000010));
    step(); ext_stall = 1; samp(); chk_eq("t4_ext1", 32'(ctrl_t), 32'(9'b111100000));
    step(); samp(); chk_eq("t4_ext2", 32'(ctrl_t), 32'(9'b111100000));
    step(); ext_stall = 0; samp();
    chk_eq("t4_w2", 32'(ctrl_t), 32'(9'b111000010));
    chk_eq("t4_w2_tmo", 32'(t_cp2_timeout), 32'h0);
    step(); samp();
    chk_eq("t4_tmo_flush", 32'(ctrl_t), 32'(9'b000011100));
    chk_eq("t4_tmo_early", 32'(t_cp2_timeout), 32'h0);
    step(); cp_irenable_0 = 0; cp2_busy = 0; samp();
    chk_eq("t4_vec_ctrl", 32'(ctrl_t), 32'(9'b000010001));
    chk_eq("t4_vec_pc", 32'(t_redirect_pc), 32'h40);
    chk_eq("t4_tmo", 32'(t_cp2_timeout), 32'h1);
    chk_eq("t4_code", 32'(t_exc_code), 32'h7);
    chk_eq("t4_epc", 32'(t_epc), 32'h123);
    step(); quiet(); samp();
    chk_eq("t4_run", 32'(ctrl_t), 32'h0);
    chk_eq("t4_sticky", 32'(t_cp2_timeout), 32'h1);
    chk_eq("m_no_tmo", 32'(m_cp2_timeout), 32'h0);
    $display("cp2 timeout phase done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
